feed_forward_input_sequencer: RTL and testbench

Upstream feeder for a layer of `feed_forward_node` instances. It collects one input vector from the previous layer into a local buffer. Then, for each node of the layer in turn, it reads that node's weights and bias from a synchronous weight RAM and streams serial (data, weight) beats into the node's `i_valid`/`i_data`/`i_weight` port. The bias beat closes each node's stream, and a programmable idle gap separates consecutive nodes.

---
 rtl/feed_forward_input_sequencer_pkg.sv | 24 ++
 rtl/ff_seq_input_buffer.sv | 36 +++
 rtl/feed_forward_input_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_feed_forward_input_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feed_forward_input_sequencer_pkg.sv
// Shared types and helpers for feed_forward_input_sequencer.
// Holds the FSM state encoding, the default bias word and the weight address map.
package feed_forward_input_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_STREAM,
        ST_GAP,
        ST_DRAIN
    } ff_seq_state_e;

    localparam logic [31:0] FF_SEQ_BIAS_DATA = 32'h3F80_0000;
    localparam int          FF_SEQ_GAP_W     = 4;

    // Node n owns N weights followed by its bias, packed back to back.
    function automatic int unsigned ff_seq_weight_addr(
        input int unsigned node,
        input int unsigned beat,
        input int unsigned n_inputs
    );
        return node * (n_inputs + 1) + beat;
    endfunction

endpackage

// File: rtl/ff_seq_input_buffer.sv
// Input-vector register file for feed_forward_input_sequencer.
// Sequential write index with wrap, combinational indexed read.
module ff_seq_input_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_last,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      wr_idx;

    assign wr_last = (int'(wr_idx) == DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
            wr_idx      <= wr_last ? '0 : wr_idx + 1'b1;
        end
    end

    assign rd_data = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/feed_forward_input_sequencer.sv
// Collects one input vector, then streams (data, weight) beats per node.
// Optional FF_SEQ_OVERRUN_CHECK_EN builds the sticky overrun flag on o_error.
module feed_forward_input_sequencer
    import feed_forward_input_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH           = 32,
    parameter int ADDRESS_WIDTH        = 5,
    parameter int NUMBER_OF_INPUT_NODE = 2,
    parameter int NUMBER_OF_NODE       = 2,
    parameter int NODE_GAP             = 3,
    parameter logic [DATA_WIDTH-1:0] BIAS_DATA =
        DATA_WIDTH'(FF_SEQ_BIAS_DATA)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic                     o_ready,
    output logic [ADDRESS_WIDTH-1:0] o_weight_addr,
    input  logic [DATA_WIDTH-1:0]    i_weight,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic [DATA_WIDTH-1:0]    o_weight,
    output logic                     o_last,
    output logic [((NUMBER_OF_NODE > 1) ?
                   $clog2(NUMBER_OF_NODE) : 1)-1:0] o_node,
    output logic                     o_done,
    output logic                     o_error
);

    localparam int N      = NUMBER_OF_INPUT_NODE;
    localparam int M      = NUMBER_OF_NODE;
    localparam int K_W    = (N > 1) ? $clog2(N) : 1;
    localparam int BEAT_W = $clog2(N + 1);
    localparam int NODE_W = (M > 1) ? $clog2(M) : 1;
    localparam int GAP_W  = FF_SEQ_GAP_W;

    ff_seq_state_e     state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic issue, issue_last, issue_done;

    logic              s1_valid, s1_last, s1_done;
    logic [BEAT_W-1:0] s1_beat;
    logic [NODE_W-1:0] s1_node;

    logic                  wr_en, wr_last;
    logic [DATA_WIDTH-1:0] rd_data;

    assign o_ready = (state_q == ST_COLLECT);
    assign wr_en   = o_ready && i_valid;

    ff_seq_input_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (N),
        .IDX_W      (K_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (i_data),
        .wr_last (wr_last),
        .rd_idx  (K_W'(s1_beat)),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            beat_q  <= '0;
            node_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            node_q  <= node_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        node_d     = node_q;
        gap_d      = gap_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_done = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                if (i_valid && wr_last) begin
                    state_d = ST_STREAM;
                    beat_d  = '0;
                    node_d  = '0;
                end
            end
            ST_STREAM: begin
                issue = 1'b1;
                if (beat_q == BEAT_W'(N)) begin
                    issue_last = 1'b1;
                    beat_d     = '0;
                    gap_d      = '0;
                    if (node_q == NODE_W'(M - 1)) begin
                        issue_done = 1'b1;
                        state_d    = ST_DRAIN;
                    end else if (NODE_GAP == 0) begin
                        node_d = node_q + 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(NODE_GAP - 1)) begin
                    state_d = ST_STREAM;
                    node_d  = node_q + 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Stage 2 drains by itself; only stage 1 must be empty.
                if (!s1_valid) begin
                    state_d = ST_COLLECT;
                end
            end
        endcase
    end

    assign o_weight_addr = (state_q == ST_STREAM) ?
        ADDRESS_WIDTH'(ff_seq_weight_addr(32'(node_q),
                                          32'(beat_q),
                                          N)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_done  <= 1'b0;
            s1_beat  <= '0;
            s1_node  <= '0;
        end else begin
            s1_valid <= issue;
            s1_last  <= issue_last;
            s1_done  <= issue_done;
            s1_beat  <= beat_q;
            s1_node  <= node_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_done   <= 1'b0;
            o_data   <= '0;
            o_weight <= '0;
            o_node   <= '0;
        end else begin
            o_valid <= s1_valid;
            o_last  <= s1_valid && s1_last;
            o_done  <= s1_valid && s1_done;
            if (s1_valid) begin
                o_data   <= s1_last ? BIAS_DATA : rd_data;
                o_weight <= i_weight;
                o_node   <= s1_node;
            end
        end
    end

`ifdef FF_SEQ_OVERRUN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_error <= 1'b0;
        end else if (i_valid && !o_ready) begin
            o_error <= 1'b1;
        end
    end
`else
    assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_feed_forward_input_sequencer.sv
// Bench for feed_forward_input_sequencer: beat-schedule model plus directed pins.
// o_error expectations follow FF_SEQ_OVERRUN_CHECK_EN.
module tb_feed_forward_input_sequencer;

    localparam int N    = 2;
    localparam int M    = 2;
    localparam int G    = 3;
    localparam int BUSY = M * (N + 1) + (M - 1) * G + 2;
    localparam logic [31:0] BIAS = 32'h3F80_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wt, b_wt;
    logic        a_ovalid, b_ovalid;
    logic [31:0] a_odata, b_odata, a_oweight, b_oweight;
    logic        a_last, b_last, a_done, b_done, a_err, b_err;
    logic [0:0]  a_node, b_node;

    logic [31:0] ram [32];

    feed_forward_input_sequencer #(.NODE_GAP(G)) dut_a (
        .clk(clk), .rst(rst), .i_valid(a_valid), .i_data(a_data),
        .o_ready(a_ready), .o_weight_addr(a_addr), .i_weight(a_wt),
        .o_valid(a_ovalid), .o_data(a_odata), .o_weight(a_oweight),
        .o_last(a_last), .o_node(a_node), .o_done(a_done),
        .o_error(a_err)
    );

    feed_forward_input_sequencer #(.NODE_GAP(0)) dut_b (
        .clk(clk), .rst(rst), .i_valid(b_valid), .i_data(b_data),
        .o_ready(b_ready), .o_weight_addr(b_addr), .i_weight(b_wt),
        .o_valid(b_ovalid), .o_data(b_odata), .o_weight(b_oweight),
        .o_last(b_last), .o_node(b_node), .o_done(b_done),
        .o_error(b_err)
    );

    always @(posedge clk) begin
        a_wt <= ram[a_addr];
        b_wt <= ram[b_addr];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act,
                        input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          gen;
        logic [31:0] d;
        logic [31:0] w;
        logic        last;
        logic        node;
        logic        done;
    } beat_t;

    beat_t       expq [int];
    logic [31:0] mbuf [N];
    int          busy_until = 0;
    int          gen = 0;
    int          mk = 0;
    logic        merr = 1'b0;

    // Model: a captured vector schedules every beat of the layer pass
    // at a fixed cycle offset; ready is low for the whole busy window.
    always @(posedge clk) begin : model
        beat_t e;
        #1;
        cyc++;
        if (rst) begin
            mk         = 0;
            busy_until = cyc;
            gen++;
            merr       = 1'b0;
        end else if (a_valid) begin
            if (cyc - 1 >= busy_until) begin
                mbuf[mk] = a_data;
                mk++;
                if (mk == N) begin
                    mk = 0;
                    for (int n = 0; n < M; n++) begin
                        for (int b = 0; b <= N; b++) begin
                            e.gen  = gen;
                            e.d    = (b < N) ? mbuf[b] : BIAS;
                            e.w    = ram[n * (N + 1) + b];
                            e.last = (b == N);
                            e.node = 1'(n);
                            e.done = (b == N) && (n == M - 1);
                            expq[cyc + 2 + n * (N + 1 + G) + b] = e;
                        end
                    end
                    busy_until = cyc + BUSY;
                end
            end else begin
`ifdef FF_SEQ_OVERRUN_CHECK_EN
                merr = 1'b1;
`endif
            end
        end
        chk1("ready", a_ready, cyc >= busy_until);
        chk1("error", a_err, merr);
        if (expq.exists(cyc) && expq[cyc].gen == gen) begin
            e = expq[cyc];
            chk1("valid", a_ovalid, 1'b1);
            chk32("data", a_odata, e.d);
            chk32("weight", a_oweight, e.w);
            chk1("last", a_last, e.last);
            chk1("node", a_node, e.node);
            chk1("done", a_done, e.done);
        end else begin
            chk1("idle valid", a_ovalid, 1'b0);
            chk1("idle last", a_last, 1'b0);
            chk1("idle done", a_done, 1'b0);
        end
    end

    task automatic feed_a(input logic [31:0] x0, input logic [31:0] x1,
                          output int e);
        a_valid = 1'b1;
        a_data  = x0;
        @(negedge clk);
        a_data = x1;
        @(negedge clk);
        a_valid = 1'b0;
        e = cyc;
    endtask

    initial begin
        int e, e2, fv, fr, lv, nb;
        logic seen;
        for (int i = 0; i < 32; i++) begin
            ram[i] = 32'h3F00_0000 + 32'(i);
        end
        repeat (3) @(negedge clk);
        chk1("rst ready", a_ready, 1'b1);
        chk1("rst valid", a_ovalid, 1'b0);
        chk32("rst addr", 32'(a_addr), 32'h0);
        chk32("rst data", a_odata, 32'h0);
        chk32("rst weight", a_oweight, 32'h0);
        chk1("rst last", a_last, 1'b0);
        chk1("rst done", a_done, 1'b0);
        chk1("rst node", a_node, 1'b0);
        chk1("rst error", a_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Pass 1: reference vector, pinned beats and latency.
        feed_a(32'h4000_0000, 32'h4040_0000, e);
        chk32("addr first", 32'(a_addr), 32'h0);
        fv = -1;
        fr = -1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (a_ovalid && fv < 0) fv = j;
            if (a_ready && fr < 0) fr = j;
            case (j)
                2: begin
                    chk32("p1 d0", a_odata, 32'h4000_0000);
                    chk32("p1 w0", a_oweight, 32'h3F00_0000);
                end
                4: begin
                    chk32("p1 bias d", a_odata, 32'h3F80_0000);
                    chk32("p1 bias w", a_oweight, 32'h3F00_0002);
                    chk1("p1 bias last", a_last, 1'b1);
                end
                6: chk1("p1 gap", a_ovalid, 1'b0);
                8: begin
                    chk1("p1 n1 node", a_node, 1'b1);
                    chk32("p1 n1 d0", a_odata, 32'h4000_0000);
                    chk32("p1 n1 w0", a_oweight, 32'h3F00_0003);
                end
                10: begin
                    chk1("p1 done", a_done, 1'b1);
                    chk32("p1 w5", a_oweight, 32'h3F00_0005);
                end
                default: ;
            endcase
        end
        chk32("first valid latency", 32'(fv), 32'd2);
        chk32("busy cycles", 32'(fr), 32'd11);

        // Pass 2: overrun beat while streaming must not touch the buffer.
        feed_a(32'h4000_0000, 32'h4040_0000, e);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 3) begin
                a_valid = 1'b1;
                a_data  = 32'hDEAD_BEEF;
            end else begin
                a_valid = 1'b0;
            end
            if (j == 8) chk32("p2 n1 d0", a_odata, 32'h4000_0000);
            if (j == 9) chk32("p2 n1 d1", a_odata, 32'h4040_0000);
        end
`ifdef FF_SEQ_OVERRUN_CHECK_EN
        chk1("overrun flag", a_err, 1'b1);
`else
        chk1("overrun flag", a_err, 1'b0);
`endif

        // Pass 3: back-to-back vectors.
        feed_a(32'h4100_0000, 32'h4110_0000, e);
        seen = 1'b0;
        for (int j = 1; j <= 20 && !seen; j++) begin
            @(negedge clk);
            seen = a_ready;
        end
        chk1("ready returns", seen, 1'b1);
        feed_a(32'h4200_0000, 32'h4210_0000, e2);
        chk32("b2b capture", 32'(e2 - e), 32'd13);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 2) chk32("b2b d0", a_odata, 32'h4200_0000);
            if (j == 3) chk32("b2b d1", a_odata, 32'h4210_0000);
        end
`ifdef FF_SEQ_OVERRUN_CHECK_EN
        chk1("overrun sticky", a_err, 1'b1);
`endif

        // Pass 4: reset during node 1 beat 1, then a fresh vector.
        feed_a(32'h4000_0000, 32'h4040_0000, e);
        repeat (9) @(negedge clk);
        chk1("pre-rst node", a_node, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("post-rst valid", a_ovalid, 1'b0);
        chk1("post-rst ready", a_ready, 1'b1);
        chk1("post-rst error", a_err, 1'b0);
        @(negedge clk);
        feed_a(32'h4080_0000, 32'h40A0_0000, e);
        chk32("fresh addr", 32'(a_addr), 32'h0);
        repeat (2) @(negedge clk);
        chk32("fresh d0", a_odata, 32'h4080_0000);
        chk32("fresh w0", a_oweight, 32'h3F00_0000);
        chk1("fresh node", a_node, 1'b0);
        repeat (12) @(negedge clk);

        // NODE_GAP=0 instance: six contiguous beats.
        b_valid = 1'b1;
        b_data  = 32'h4000_0000;
        @(negedge clk);
        b_data = 32'h4040_0000;
        @(negedge clk);
        b_valid = 1'b0;
        fv = -1;
        lv = -1;
        nb = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (b_ovalid) begin
                nb++;
                if (fv < 0) fv = j;
                lv = j;
            end
            if (j == 4) begin
                chk1("g0 beat3 node", b_node, 1'b0);
                chk1("g0 beat3 last", b_last, 1'b1);
            end
            if (j == 5) begin
                chk1("g0 beat4 node", b_node, 1'b1);
                chk32("g0 beat4 w", b_oweight, 32'h3F00_0003);
            end
            if (j == 7) chk1("g0 done", b_done, 1'b1);
            if (j == 8) chk1("g0 ready", b_ready, 1'b1);
        end
        chk32("g0 beats", 32'(nb), 32'd6);
        chk32("g0 first", 32'(fv), 32'd2);
        chk32("g0 last", 32'(lv), 32'd7);
        chk1("g0 error", b_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
